md5_range_search: RTL and testbench

Search controller for the MD5 breaker. It walks a numeric candidate range, streams one candidate per cycle into the pipelined `md5core`, and tracks each candidate through the hasher's fixed latency with a valid/message delay line. It compares every emerging hash against a target digest and reports the first matching message. It replaces fixed-stimulus, fixed-cycle hash checking with a parametrised, self-contained search engine.

---
 rtl/md5_range_search_if.sv | 29 ++
 rtl/md5_range_search.sv | 95 +++++++++
 tb/tb_md5_range_search.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/md5_range_search_if.sv
// md5_range_search_if: control, candidate and result bundle for the MD5 range search engine
// master: driver side (start/abort/range/target in, hash_in from the core); slave: search controller
interface md5_range_search_if #(
  parameter int MSG_W  = 64,
  parameter int HASH_W = 128
);
  logic              start;
  logic              abort;
  logic [MSG_W-1:0]  range_lo;
  logic [MSG_W-1:0]  range_hi;
  logic [HASH_W-1:0] target;
  logic [HASH_W-1:0] hash_in;
  logic [MSG_W-1:0]  cand_msg;
  logic              cand_valid;
  logic [63:0]       msg_length;
  logic              busy;
  logic              done;
  logic              found;
  logic [MSG_W-1:0]  found_msg;
  logic [MSG_W-1:0]  cand_count;
  modport master (
    output start, abort, range_lo, range_hi, target, hash_in,
    input  cand_msg, cand_valid, msg_length, busy, done, found, found_msg, cand_count
  );
  modport slave (
    input  start, abort, range_lo, range_hi, target, hash_in,
    output cand_msg, cand_valid, msg_length, busy, done, found, found_msg, cand_count
  );
endinterface

// File: rtl/md5_range_search.sv
// md5_range_search: walks [range_lo, range_hi] one candidate per cycle into a pipelined md5core and reports the first hash match
// ports: clk, rst_n (async active-low), bus (slave): start/abort/range/target in, candidate stream out, hash_in back, busy/done/found/found_msg/cand_count status
module md5_range_search #(
  parameter int MSG_W   = 64,
  parameter int MSG_LEN = 32,
  parameter int LATENCY = 65,
  parameter int HASH_W  = 128
) (
  input logic               clk,
  input logic               rst_n,
  md5_range_search_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t            r_state;
  logic [MSG_W-1:0]  r_cand;
  logic              r_cand_valid;
  logic [MSG_W-1:0]  r_hi;
  logic [HASH_W-1:0] r_target;
  logic              r_found;
  logic [MSG_W-1:0]  r_found_msg;
  logic [MSG_W-1:0]  r_cnt;
  logic              r_dv [LATENCY];
  logic [MSG_W-1:0]  r_dm [LATENCY];
  logic              w_busy;
  logic              w_hit;
  assign w_busy = r_state == RUN || r_state == DRAIN;
  // stage LATENCY-1 holds the candidate whose digest is on hash_in this cycle
  assign w_hit = w_busy && r_dv[LATENCY-1] && bus.hash_in == r_target;
  assign bus.cand_msg   = r_cand;
  assign bus.cand_valid = r_cand_valid;
  assign bus.msg_length = 64'(MSG_LEN);
  assign bus.busy       = w_busy;
  assign bus.done       = r_state == DONE;
  assign bus.found      = r_found;
  assign bus.found_msg  = r_found_msg;
  assign bus.cand_count = r_cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_cand       <= '0;
      r_cand_valid <= 1'b0;
      r_hi         <= '0;
      r_target     <= '0;
      r_found      <= 1'b0;
      r_found_msg  <= '0;
      r_cnt        <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        r_dv[i] <= 1'b0;
        r_dm[i] <= '0;
      end
    end else begin
      r_dv[0] <= r_cand_valid;
      r_dm[0] <= r_cand;
      for (int i = 1; i < LATENCY; i++) begin
        r_dv[i] <= r_dv[i-1];
        r_dm[i] <= r_dm[i-1];
      end
      if (r_cand_valid && !bus.abort)
        r_cnt <= r_cnt + MSG_W'(!(&r_cnt));
      if (bus.abort) begin
        r_state      <= IDLE;
        r_cand_valid <= 1'b0;
        for (int i = 0; i < LATENCY; i++) r_dv[i] <= 1'b0;
      end else if (w_hit) begin
        r_state      <= DONE;
        r_found      <= 1'b1;
        r_found_msg  <= r_dm[LATENCY-1];
        r_cand_valid <= 1'b0;
        for (int i = 0; i < LATENCY; i++) r_dv[i] <= 1'b0;
      end else begin
        case (r_state)
          IDLE, DONE: if (bus.start) begin
            r_hi     <= bus.range_hi;
            r_target <= bus.target;
            r_found  <= 1'b0;
            r_cnt    <= '0;
            for (int i = 0; i < LATENCY; i++) r_dv[i] <= 1'b0;
            r_state      <= bus.range_lo > bus.range_hi ? DONE : RUN;
            r_cand       <= bus.range_lo > bus.range_hi ? r_cand : bus.range_lo;
            r_cand_valid <= bus.range_lo <= bus.range_hi;
          end
          // stopping on equality with range_hi keeps an all-ones upper bound from wrapping
          RUN: if (r_cand == r_hi) begin
            r_state      <= DRAIN;
            r_cand_valid <= 1'b0;
          end else
            r_cand <= r_cand + MSG_W'(1);
          // every candidate is issued exactly once, so range_hi reaching the compare stage marks the last one
          DRAIN: if (r_dv[LATENCY-1] && r_dm[LATENCY-1] == r_hi) r_state <= DONE;
          default: r_state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_md5_range_search.sv
// tb_md5_range_search: scoreboard bench for md5_range_search using a delayed stub hasher and a reference search model
module tb_md5_range_search;
  localparam int LAT = 4;
  typedef struct {
    logic        f;
    logic [63:0] m;
    logic [63:0] c;
    int          rel;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t0 = 0;
  logic armed = 1'b0;
  logic [63:0] exp_next = '0;
  exp_t q[$];
  exp_t e;
  logic [63:0] pipe [LAT];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  md5_range_search_if #(.MSG_W(64), .HASH_W(128)) bus ();
  md5_range_search #(.MSG_W(64), .MSG_LEN(32), .LATENCY(LAT), .HASH_W(128)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  function automatic logic [127:0] stub(input logic [63:0] m);
    return {64'hA5A5A5A5A5A5A5A5, m};
  endfunction
  always @(posedge clk) begin
    pipe[0] <= bus.cand_msg;
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign bus.hash_in = stub(pipe[LAT-1]);
  // reference: scan the range in order for the first candidate whose stub digest equals the target;
  // issuing stops in the cycle that candidate is compared, LAT cycles after it was issued
  function automatic exp_t model(input logic [63:0] lo, input logic [63:0] hi, input logic [127:0] tgt);
    exp_t r;
    logic [63:0] n;
    r = '{f: 1'b0, m: 64'd0, c: 64'd0, rel: 1};
    if (lo > hi) return r;
    n = hi - lo + 64'd1;
    r.c = n;
    r.rel = int'(n) + LAT + 1;
    for (longint unsigned i = 0; i < n; i++)
      if (stub(lo + i) == tgt) begin
        r.f = 1'b1;
        r.m = lo + i;
        r.c = (i + 1 + LAT < n) ? i + 1 + LAT : n;
        r.rel = int'(i) + LAT + 2;
        return r;
      end
    return r;
  endfunction
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  task automatic chk_reset();
    chk("rst_cand_msg", bus.cand_msg, 64'd0);
    chk("rst_cand_valid", 64'(bus.cand_valid), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_found", 64'(bus.found), 64'd0);
    chk("rst_found_msg", bus.found_msg, 64'd0);
    chk("rst_cand_count", bus.cand_count, 64'd0);
  endtask
  always @(negedge clk) if (rst_n) begin
    if (bus.cand_valid) begin
      chk("cand_msg_seq", bus.cand_msg, exp_next);
      exp_next = exp_next + 64'd1;
    end
    if (armed && bus.done) begin
      armed = 1'b0;
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_empty: done seen with no expectation queued");
      end else begin
        e = q.pop_front();
        chk("found", 64'(bus.found), 64'(e.f));
        if (e.f) chk("found_msg", bus.found_msg, e.m);
        chk("cand_count", bus.cand_count, e.c);
        chk("done_cycle", 64'(cyc - t0 + 1), 64'(e.rel));
        chk("busy_at_done", 64'(bus.busy), 64'd0);
        chk("valid_at_done", 64'(bus.cand_valid), 64'd0);
      end
    end
  end
  task automatic start_run(input logic [63:0] lo, input logic [63:0] hi, input logic [127:0] tgt, input bit expect_done);
    @(negedge clk);
    bus.range_lo = lo;
    bus.range_hi = hi;
    bus.target = tgt;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    t0 = cyc;
    exp_next = lo;
    if (expect_done) begin
      q.push_back(model(lo, hi, tgt));
      armed = 1'b1;
    end
  endtask
  task automatic wait_done();
    for (int k = 0; k < 300 && armed; k++) @(posedge clk);
    if (armed) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: done never rose, got busy=%0b expected done=1", bus.busy);
      armed = 1'b0;
      q.delete();
    end
    repeat (2) @(negedge clk);
  endtask
  task automatic run(input logic [63:0] lo, input logic [63:0] hi, input logic [127:0] tgt);
    start_run(lo, hi, tgt, 1'b1);
    wait_done();
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    logic [63:0] lo, hi;
    logic [127:0] tgt;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.range_lo = '0;
    bus.range_hi = '0;
    bus.target = '0;
    repeat (3) @(negedge clk);
    chk_reset();
    chk("msg_length", bus.msg_length, 64'd32);
    rst_n = 1'b1;
    run(64'd0, 64'd9, stub(64'd5));
    run(64'd0, 64'd9, {64'd0, 64'd5});
    run(64'd10, 64'd3, stub(64'd5));
    run(64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF, {64'd0, 64'd1});
    run(64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF, stub(64'hFFFF_FFFF_FFFF_FFFF));
    run(64'd0, 64'd9, stub(64'd9));
    // abort in the third run cycle, well before candidate 1 reaches the compare stage
    start_run(64'd0, 64'd9, stub(64'd1), 1'b0);
    repeat (3) @(negedge clk);
    bus.abort = 1'b1;
    @(posedge clk);
    #1;
    bus.abort = 1'b0;
    @(negedge clk);
    chk("abort_busy", 64'(bus.busy), 64'd0);
    chk("abort_done", 64'(bus.done), 64'd0);
    chk("abort_valid", 64'(bus.cand_valid), 64'd0);
    repeat (10) @(negedge clk);
    chk("abort_no_found", 64'(bus.found), 64'd0);
    // abort in the very cycle candidate 0 matches
    start_run(64'd0, 64'd9, stub(64'd0), 1'b0);
    repeat (5) @(negedge clk);
    bus.abort = 1'b1;
    @(posedge clk);
    #1;
    bus.abort = 1'b0;
    repeat (8) @(negedge clk);
    chk("abort_vs_match_found", 64'(bus.found), 64'd0);
    chk("abort_vs_match_done", 64'(bus.done), 64'd0);
    // a second start mid-run must be ignored
    start_run(64'd0, 64'd9, {64'd0, 64'd3}, 1'b1);
    repeat (3) @(negedge clk);
    bus.range_lo = 64'd100;
    bus.range_hi = 64'd200;
    bus.target = stub(64'd150);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done();
    // asynchronous reset while draining
    start_run(64'd0, 64'd9, {64'd0, 64'd3}, 1'b0);
    repeat (12) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset();
    @(negedge clk);
    rst_n = 1'b1;
    run(64'd3, 64'd3, stub(64'd3));
    for (int it = 0; it < 25; it++) begin
      lo = {$urandom, $urandom};
      if ($urandom_range(0, 7) == 0) begin
        lo = lo | 64'h10;
        hi = lo - 64'($urandom_range(1, 15));
      end else begin
        hi = lo + 64'($urandom_range(0, 15));
        if (hi < lo) hi = '1;
      end
      tgt = $urandom_range(0, 2) == 0 ? {64'd0, lo} : stub(lo + 64'($urandom_range(0, 16)));
      run(lo, hi, tgt);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
